// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the miniRV datapath.
// Optional retired-instruction counter: define MULTICYCLE_CTRL_INSTRET_EN.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int INSTRET_W   = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] inst_i,
    input  logic        br_taken_i,
    input  logic        imem_ack_i,
    input  logic        dmem_ack_i,
    output logic        imem_req_o,
    output logic        ir_we_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic        rf_we_o,
    output logic [2:0]  sext_op_o,
    output logic [2:0]  wd_sel_o,
    output logic        pc_we_o,
    output logic [1:0]  npc_sel_o,
    output logic [2:0]  state_o,
    output logic        trap_o,
    output logic [1:0]  trap_cause_o
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    ,
    output logic [INSTRET_W-1:0] instret_o
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam int CNT_W = $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [1:0]       trap_cause;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic       is_load, is_store, is_br, is_jal, is_jalr, legal;
    logic [2:0] sext_dec, wd_dec;
    logic       unused_inst_hi;

    assign opcode         = inst_i[6:0];
    assign rd             = inst_i[11:7];
    assign unused_inst_hi = ^inst_i[31:12];

    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_br    = (opcode == OP_BR);
    assign is_jal   = (opcode == OP_JAL);
    assign is_jalr  = (opcode == OP_JALR);

    always_comb begin
        sext_dec = 3'b000;
        wd_dec   = 3'b000;
        legal    = 1'b1;
        case (opcode)
            OP_R:     begin sext_dec = 3'b000; wd_dec = 3'b000; end
            OP_I:     begin sext_dec = 3'b000; wd_dec = 3'b000; end
            OP_LOAD:  begin sext_dec = 3'b000; wd_dec = 3'b010; end
            OP_STORE: begin sext_dec = 3'b001; wd_dec = 3'b000; end
            OP_BR:    begin sext_dec = 3'b010; wd_dec = 3'b000; end
            OP_LUI:   begin sext_dec = 3'b011; wd_dec = 3'b011; end
            OP_AUIPC: begin sext_dec = 3'b011; wd_dec = 3'b100; end
            OP_JAL:   begin sext_dec = 3'b100; wd_dec = 3'b001; end
            OP_JALR:  begin sext_dec = 3'b000; wd_dec = 3'b001; end
            default:  legal = 1'b0;
        endcase
    end

    // Memory handshake: a request is held high every cycle until the cycle in
    // which ack is seen; that cycle completes the transfer. A request that
    // waits MEM_TIMEOUT cycles without ack traps, but an ack in the last
    // cycle still completes normally.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= S_FETCH;
            wait_cnt   <= '0;
            trap_cause <= 2'b00;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack_i) begin
                        state    <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_LAST) begin
                        state      <= S_TRAP;
                        trap_cause <= 2'b01;
                        wait_cnt   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        state <= S_EXEC;
                    end else begin
                        state      <= S_TRAP;
                        trap_cause <= 2'b11;
                    end
                end
                S_EXEC: begin
                    if (is_load || is_store) state <= S_MEM;
                    else if (is_br)          state <= S_FETCH;
                    else                     state <= S_WB;
                end
                S_MEM: begin
                    if (dmem_ack_i) begin
                        state    <= is_store ? S_FETCH : S_WB;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_LAST) begin
                        state      <= S_TRAP;
                        trap_cause <= 2'b10;
                        wait_cnt   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB:    state <= S_FETCH;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_TRAP;
            endcase
        end
    end

    // Every output is held at zero while reset is asserted, including state_o.
    always_comb begin
        imem_req_o   = 1'b0;
        ir_we_o      = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        rf_we_o      = 1'b0;
        sext_op_o    = 3'b000;
        wd_sel_o     = 3'b000;
        pc_we_o      = 1'b0;
        npc_sel_o    = 2'b00;
        state_o      = 3'b000;
        trap_o       = 1'b0;
        trap_cause_o = 2'b00;
        if (rst_i) begin
            state_o      = state;
            trap_cause_o = trap_cause;
            if (state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB) begin
                sext_op_o = sext_dec;
                wd_sel_o  = wd_dec;
            end
            case (state)
                S_FETCH: begin
                    imem_req_o = 1'b1;
                    ir_we_o    = imem_ack_i;
                end
                S_EXEC: begin
                    if (is_br) begin
                        pc_we_o   = 1'b1;
                        npc_sel_o = br_taken_i ? 2'b01 : 2'b00;
                    end
                end
                S_MEM: begin
                    dmem_req_o = 1'b1;
                    dmem_we_o  = is_store;
                    pc_we_o    = dmem_ack_i && is_store;
                end
                S_WB: begin
                    rf_we_o   = (rd != 5'd0);
                    pc_we_o   = 1'b1;
                    npc_sel_o = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
                end
                S_TRAP:  trap_o = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MULTICYCLE_CTRL_INSTRET_EN
    logic [INSTRET_W-1:0] instret;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)       instret <= '0;
        else if (pc_we_o) instret <= instret + 1'b1;
    end

    assign instret_o = instret;
`else
    localparam int unused_instret_w = INSTRET_W;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (default build, MEM_TIMEOUT=16).
module tb_multicycle_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] inst_i = 32'h0;
    logic        br_taken_i = 1'b0;
    logic        imem_ack_i = 1'b0;
    logic        dmem_ack_i = 1'b0;
    logic        imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, rf_we_o, pc_we_o, trap_o;
    logic [2:0]  sext_op_o, wd_sel_o, state_o;
    logic [1:0]  npc_sel_o, trap_cause_o;
    logic [19:0] all_out;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(16), .INSTRET_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .inst_i(inst_i), .br_taken_i(br_taken_i),
        .imem_ack_i(imem_ack_i), .dmem_ack_i(dmem_ack_i),
        .imem_req_o(imem_req_o), .ir_we_o(ir_we_o), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .rf_we_o(rf_we_o), .sext_op_o(sext_op_o),
        .wd_sel_o(wd_sel_o), .pc_we_o(pc_we_o), .npc_sel_o(npc_sel_o),
        .state_o(state_o), .trap_o(trap_o), .trap_cause_o(trap_cause_o)
    );

    assign all_out = {imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, rf_we_o, sext_op_o,
                      wd_sel_o, pc_we_o, npc_sel_o, state_o, trap_o, trap_cause_o};

    always #5 clk_i = ~clk_i;

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic next_cycle(input logic ia, input logic da, input logic bt);
        @(negedge clk_i);
        imem_ack_i = ia;
        dmem_ack_i = da;
        br_taken_i = bt;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
        br_taken_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] inst, input string tag);
        @(negedge clk_i);
        inst_i = inst;
        imem_ack_i = 1'b1;
        dmem_ack_i = 1'b0;
        br_taken_i = 1'b0;
        #1;
        checks++;
        if ({state_o, imem_req_o, ir_we_o} !== {3'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL %s_fetch: state/imem_req/ir_we got %b want 000_1_1", tag,
                     {state_o, imem_req_o, ir_we_o});
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        imem_ack_i = 1'b1;
        dmem_ack_i = 1'b1;
        br_taken_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        checks++;
        if (all_out !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 00000", all_out);
        end
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
        br_taken_i = 1'b0;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({state_o, imem_req_o, trap_o, trap_cause_o} !== {3'd0, 1'b1, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL reset_release: got %b want 000_1_0_00",
                     {state_o, imem_req_o, trap_o, trap_cause_o});
        end
    endtask

    // Non-memory, non-branch instruction through DECODE, EXEC, WB.
    task automatic run_wb(input logic [31:0] inst, input logic exp_rf, input logic [2:0] exp_wd,
                          input logic [2:0] exp_sext, input logic [1:0] exp_npc, input string tag);
        do_fetch(inst, tag);
        next_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if ({state_o, sext_op_o, wd_sel_o} !== {3'd1, exp_sext, exp_wd}) begin
            errors++;
            $display("FAIL %s_decode: state/sext/wd got %b want %b", tag,
                     {state_o, sext_op_o, wd_sel_o}, {3'd1, exp_sext, exp_wd});
        end
        next_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if ({state_o, pc_we_o, rf_we_o} !== {3'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s_exec: state/pc_we/rf_we got %b want 010_0_0", tag,
                     {state_o, pc_we_o, rf_we_o});
        end
        next_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if ({state_o, rf_we_o, wd_sel_o, sext_op_o, pc_we_o, npc_sel_o} !==
            {3'd4, exp_rf, exp_wd, exp_sext, 1'b1, exp_npc}) begin
            errors++;
            $display("FAIL %s_wb: state/rf_we/wd/sext/pc_we/npc got %b want %b", tag,
                     {state_o, rf_we_o, wd_sel_o, sext_op_o, pc_we_o, npc_sel_o},
                     {3'd4, exp_rf, exp_wd, exp_sext, 1'b1, exp_npc});
        end
    endtask

    task automatic test_alu_and_jumps();
        run_wb(32'h00500093, 1'b1, 3'b000, 3'b000, 2'b00, "addi");
        run_wb(32'h002081B3, 1'b1, 3'b000, 3'b000, 2'b00, "add");
        run_wb(32'h008000EF, 1'b1, 3'b001, 3'b100, 2'b01, "jal");
        run_wb(32'h000080E7, 1'b1, 3'b001, 3'b000, 2'b10, "jalr");
        run_wb(32'h000012B7, 1'b1, 3'b011, 3'b011, 2'b00, "lui");
        run_wb(32'h00001297, 1'b1, 3'b100, 3'b011, 2'b00, "auipc");
        run_wb(32'h00100013, 1'b0, 3'b000, 3'b000, 2'b00, "addi_x0");
    endtask

    task automatic test_load();
        do_fetch(32'h0000A103, "lw");
        next_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if ({state_o, sext_op_o, wd_sel_o} !== {3'd1, 3'b000, 3'b010}) begin
            errors++;
            $display("FAIL lw_decode: got %b want 001_000_010", {state_o, sext_op_o, wd_sel_o});
        end
        next_cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            next_cycle(1'b0, (i == 3), 1'b0);
            checks++;
            if ({state_o, dmem_req_o, dmem_we_o, pc_we_o, rf_we_o} !== {3'd3, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL lw_mem%0d: state/req/we/pc_we/rf_we got %b want 011_1_0_0_0", i,
                         {state_o, dmem_req_o, dmem_we_o, pc_we_o, rf_we_o});
            end
        end
        next_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if ({state_o, rf_we_o, wd_sel_o, pc_we_o, npc_sel_o, dmem_req_o} !==
            {3'd4, 1'b1, 3'b010, 1'b1, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL lw_wb: got %b want 100_1_010_1_00_0",
                     {state_o, rf_we_o, wd_sel_o, pc_we_o, npc_sel_o, dmem_req_o});
        end
    endtask

    task automatic test_store();
        do_fetch(32'h0020A023, "sw");
        next_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if ({state_o, sext_op_o, rf_we_o} !== {3'd1, 3'b001, 1'b0}) begin
            errors++;
            $display("FAIL sw_decode: got %b want 001_001_0", {state_o, sext_op_o, rf_we_o});
        end
        next_cycle(1'b0, 1'b0, 1'b0);
        next_cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if ({state_o, dmem_req_o, dmem_we_o, pc_we_o, npc_sel_o, rf_we_o} !==
            {3'd3, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL sw_mem_ack: got %b want 011_1_1_1_00_0",
                     {state_o, dmem_req_o, dmem_we_o, pc_we_o, npc_sel_o, rf_we_o});
        end
        next_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if ({state_o, rf_we_o, dmem_req_o} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sw_next_fetch: got %b want 000_0_0", {state_o, rf_we_o, dmem_req_o});
        end
    endtask

    task automatic test_branch(input logic taken);
        do_fetch(32'h00000463, "beq");
        next_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if ({state_o, sext_op_o} !== {3'd1, 3'b010}) begin
            errors++;
            $display("FAIL beq_decode: got %b want 001_010", {state_o, sext_op_o});
        end
        next_cycle(1'b0, 1'b0, taken);
        checks++;
        if ({state_o, pc_we_o, npc_sel_o, sext_op_o, rf_we_o} !==
            {3'd2, 1'b1, {1'b0, taken}, 3'b010, 1'b0}) begin
            errors++;
            $display("FAIL beq_exec_taken%0d: got %b want %b", taken,
                     {state_o, pc_we_o, npc_sel_o, sext_op_o, rf_we_o},
                     {3'd2, 1'b1, {1'b0, taken}, 3'b010, 1'b0});
        end
        next_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (state_o !== 3'd0) begin
            errors++;
            $display("FAIL beq_no_wb: state got %0d want 0", state_o);
        end
    endtask

    task automatic test_illegal();
        do_fetch(32'h0000007F, "illegal");
        next_cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            next_cycle(1'b1, 1'b1, 1'b1);
            checks++;
            if ({state_o, trap_o, trap_cause_o, imem_req_o, ir_we_o, dmem_req_o, pc_we_o, rf_we_o} !==
                {3'd5, 1'b1, 2'b11, 5'b00000}) begin
                errors++;
                $display("FAIL illegal_trap%0d: got %b want 101_1_11_00000", i,
                         {state_o, trap_o, trap_cause_o, imem_req_o, ir_we_o, dmem_req_o, pc_we_o, rf_we_o});
            end
        end
        apply_reset();
        checks++;
        if ({state_o, trap_o, trap_cause_o} !== {3'd0, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL illegal_reset_exit: got %b want 000_0_00", {state_o, trap_o, trap_cause_o});
        end
    endtask

    task automatic test_imem_timeout();
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            next_cycle(1'b0, 1'b0, 1'b0);
            checks++;
            if ({state_o, imem_req_o} !== {3'd0, 1'b1}) begin
                errors++;
                $display("FAIL imem_wait%0d: got %b want 000_1", i, {state_o, imem_req_o});
            end
        end
        next_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if ({state_o, trap_o, trap_cause_o, imem_req_o} !== {3'd5, 1'b1, 2'b01, 1'b0}) begin
            errors++;
            $display("FAIL imem_timeout: got %b want 101_1_01_0", {state_o, trap_o, trap_cause_o, imem_req_o});
        end
    endtask

    task automatic test_ack_at_timeout();
        inst_i = 32'h00500093;
        apply_reset();
        repeat (14) next_cycle(1'b0, 1'b0, 1'b0);
        next_cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if ({state_o, ir_we_o} !== {3'd0, 1'b1}) begin
            errors++;
            $display("FAIL ack_last_cycle: got %b want 000_1", {state_o, ir_we_o});
        end
        next_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if ({state_o, trap_o} !== {3'd1, 1'b0}) begin
            errors++;
            $display("FAIL ack_last_decode: got %b want 001_0", {state_o, trap_o});
        end
    endtask

    task automatic test_dmem_timeout();
        apply_reset();
        do_fetch(32'h0000A103, "lw_to");
        next_cycle(1'b0, 1'b0, 1'b0);
        next_cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            next_cycle(1'b0, 1'b0, 1'b0);
            checks++;
            if ({state_o, dmem_req_o} !== {3'd3, 1'b1}) begin
                errors++;
                $display("FAIL dmem_wait%0d: got %b want 011_1", i, {state_o, dmem_req_o});
            end
        end
        next_cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if ({state_o, trap_o, trap_cause_o, dmem_req_o, rf_we_o} !== {3'd5, 1'b1, 2'b10, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL dmem_timeout: got %b want 101_1_10_0_0",
                     {state_o, trap_o, trap_cause_o, dmem_req_o, rf_we_o});
        end
    endtask

    task automatic test_reset_mid_mem();
        apply_reset();
        do_fetch(32'h0020A023, "sw_rst");
        next_cycle(1'b0, 1'b0, 1'b0);
        next_cycle(1'b0, 1'b0, 1'b0);
        next_cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if ({state_o, dmem_req_o, dmem_we_o} !== {3'd3, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL rst_mem_entry: got %b want 011_1_1", {state_o, dmem_req_o, dmem_we_o});
        end
        dmem_ack_i = 1'b1;
        rst_i = 1'b0;
        #1;
        checks++;
        if (all_out !== 20'h0) begin
            errors++;
            $display("FAIL rst_mid_mem: got %h want 00000", all_out);
        end
        @(negedge clk_i);
        dmem_ack_i = 1'b0;
        rst_i = 1'b1;
        #1;
        checks++;
        if ({state_o, imem_req_o, dmem_req_o, pc_we_o, rf_we_o} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_mem_release: got %b want 000_1_0_0_0",
                     {state_o, imem_req_o, dmem_req_o, pc_we_o, rf_we_o});
        end
    endtask

    initial begin
        test_reset();
        test_alu_and_jumps();
        test_load();
        test_store();
        test_branch(1'b1);
        test_branch(1'b0);
        test_illegal();
        test_imem_timeout();
        test_ack_at_timeout();
        test_dmem_timeout();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
